// File: rtl/intersection.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intersection : pipelined division-free Moller-Trumbore ray/triangle test,   |
// |                signed Q16.16 inputs, exact full-precision internal maths.   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module intersection #(
    parameter logic signed [31:0] MIN_T = 32'sh0000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [2:0][2:0][31:0] i_triangle,
    input  logic [1:0][2:0][31:0] i_ray,
    output logic                  o_valid,
    output logic                  o_result,
    output logic                  o_invalid
);

    typedef logic signed [32:0]  s33_t;
    typedef logic signed [66:0]  s67_t;
    typedef logic signed [101:0] s102_t;
    typedef logic signed [102:0] s103_t;
    typedef logic signed [133:0] s134_t;

    function automatic s33_t sub33(input logic [31:0] a, input logic [31:0] b);
        return s33_t'({a[31], a}) - s33_t'({b[31], b});
    endfunction

    // a*b - c*d at full Q32.32 precision
    function automatic s67_t xprod(input s33_t a, input s33_t b, input s33_t c, input s33_t d);
        return s67_t'(a) * s67_t'(b) - s67_t'(c) * s67_t'(d);
    endfunction

    function automatic s102_t dot3(input s33_t a0, input s33_t a1, input s33_t a2,
                                   input s67_t b0, input s67_t b1, input s67_t b2);
        return s102_t'(a0) * s102_t'(b0) + s102_t'(a1) * s102_t'(b1) + s102_t'(a2) * s102_t'(b2);
    endfunction

    // Stage valid bits and registered outputs
    logic vld1_q, vld2_q, vld3_q, vld4_q;
    logic out_valid_q, out_result_q, out_invalid_q;
    logic out_result_d, out_invalid_d;

    // S1: captured inputs
    logic [31:0] vtx_q [3][3];
    logic [31:0] org_q [3];
    logic [31:0] dir_q [3];

    // S2: differences and overflow flag
    s33_t e1_d [3], e2_d [3], t_d [3], dir_d [3];
    logic ovf_d;
    s33_t e1_q [3], e2_q [3], t_q [3], dir2_q [3];
    logic ovf2_q;

    // S3: cross products
    s67_t p_d [3], q_d [3];
    s67_t p_q [3], q_q [3];
    s33_t e1_3q [3], e2_3q [3], t_3q [3], dir3_q [3];
    logic ovf3_q;

    // S4: triple products and scaled threshold
    s102_t det_d, u_d, v_d, tn_d;
    s134_t m_d;
    s102_t det_q, u_q, v_q, tn_q;
    s134_t m_q;
    logic  ovf4_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld1_q        <= 1'b0;
            vld2_q        <= 1'b0;
            vld3_q        <= 1'b0;
            vld4_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= 1'b0;
            out_invalid_q <= 1'b0;
        end else begin
            vld1_q        <= i_valid;
            vld2_q        <= vld1_q;
            vld3_q        <= vld2_q;
            vld4_q        <= vld3_q;
            out_valid_q   <= vld4_q;
            out_result_q  <= out_result_d;
            out_invalid_q <= out_invalid_d;
        end
    end

    // Datapath registers carry no reset; their contents are qualified by the valid bits.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 3; k++) begin
                vtx_q[k][c] <= i_triangle[k][c];
            end
            org_q[c]  <= i_ray[1][c];
            dir_q[c]  <= i_ray[0][c];

            e1_q[c]   <= e1_d[c];
            e2_q[c]   <= e2_d[c];
            t_q[c]    <= t_d[c];
            dir2_q[c] <= dir_d[c];

            p_q[c]    <= p_d[c];
            q_q[c]    <= q_d[c];
            e1_3q[c]  <= e1_q[c];
            e2_3q[c]  <= e2_q[c];
            t_3q[c]   <= t_q[c];
            dir3_q[c] <= dir2_q[c];
        end
        ovf2_q <= ovf_d;
        ovf3_q <= ovf2_q;
        ovf4_q <= ovf3_q;
        det_q  <= det_d;
        u_q    <= u_d;
        v_q    <= v_d;
        tn_q   <= tn_d;
        m_q    <= m_d;
    end

    always_comb begin
        ovf_d = 1'b0;
        for (int c = 0; c < 3; c++) begin
            e1_d[c]  = sub33(vtx_q[1][c], vtx_q[0][c]);
            e2_d[c]  = sub33(vtx_q[2][c], vtx_q[0][c]);
            t_d[c]   = sub33(org_q[c], vtx_q[0][c]);
            dir_d[c] = s33_t'({dir_q[c][31], dir_q[c]});
            // A 33-bit value fits in 32 bits only when its top two bits agree
            ovf_d = ovf_d | (e1_d[c][32] ^ e1_d[c][31])
                          | (e2_d[c][32] ^ e2_d[c][31])
                          | (t_d[c][32]  ^ t_d[c][31]);
        end
    end

    always_comb begin
        p_d[0] = xprod(dir2_q[1], e2_q[2], dir2_q[2], e2_q[1]);
        p_d[1] = xprod(dir2_q[2], e2_q[0], dir2_q[0], e2_q[2]);
        p_d[2] = xprod(dir2_q[0], e2_q[1], dir2_q[1], e2_q[0]);
        q_d[0] = xprod(t_q[1], e1_q[2], t_q[2], e1_q[1]);
        q_d[1] = xprod(t_q[2], e1_q[0], t_q[0], e1_q[2]);
        q_d[2] = xprod(t_q[0], e1_q[1], t_q[1], e1_q[0]);
    end

    // m is min_t*det in Q64.64; t_n is shifted up by 16 later so both compare exactly.
    always_comb begin
        det_d = dot3(e1_3q[0], e1_3q[1], e1_3q[2], p_q[0], p_q[1], p_q[2]);
        u_d   = dot3(t_3q[0], t_3q[1], t_3q[2], p_q[0], p_q[1], p_q[2]);
        v_d   = dot3(dir3_q[0], dir3_q[1], dir3_q[2], q_q[0], q_q[1], q_q[2]);
        tn_d  = dot3(e2_3q[0], e2_3q[1], e2_3q[2], q_q[0], q_q[1], q_q[2]);
        m_d   = s134_t'(MIN_T) * s134_t'(det_d);
    end

    s103_t uv_sum;
    s103_t det_ext;
    s134_t tn_al;
    logic  hit;
    logic  invalid;

    always_comb begin
        uv_sum  = s103_t'(u_q) + s103_t'(v_q);
        det_ext = s103_t'(det_q);
        tn_al   = s134_t'(tn_q) <<< 16;
        invalid = ovf4_q | (det_q == '0);
        hit     = 1'b0;
        if (det_q > 0) begin
            hit = (u_q >= 0) && (v_q >= 0) && (uv_sum <= det_ext) && (tn_al > m_q);
        end else if (det_q < 0) begin
            hit = (u_q <= 0) && (v_q <= 0) && (uv_sum >= det_ext) && (tn_al < m_q);
        end
        out_result_d  = vld4_q & hit & ~invalid;
        out_invalid_d = vld4_q & invalid;
    end

    assign o_valid   = out_valid_q;
    assign o_result  = out_result_q;
    assign o_invalid = out_invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_intersection.sv
`default_nettype none
// Directed self-checking bench for intersection: two instances (min_t = 0 and min_t = 2.0).
module tb_intersection;

    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] HALF = 32'h0000_8000;
    localparam logic [31:0] QTR  = 32'h0000_4000;
    localparam logic [31:0] NEG1 = 32'hFFFF_0000;
    localparam logic [31:0] TWO  = 32'h0002_0000;
    localparam logic [31:0] THR  = 32'h0003_0000;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic [2:0][2:0][31:0] tri_v = '0;
    logic [1:0][2:0][31:0] ray_v = '0;
    logic                  o_valid, o_result, o_invalid;
    logic                  m_valid, m_result, m_invalid;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs per directed case: main instance (min_t=0) and min_t=2.0 instance
    string names   [0:8] = '{"centre", "behind", "outside", "edge", "parallel",
                             "overflow", "reversed", "far_t3", "t_eq_2"};
    bit    exp_res [0:8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit    exp_inv [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit    exp_mres[0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    intersection dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (in_valid),
        .i_triangle (tri_v),
        .i_ray      (ray_v),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_invalid  (o_invalid)
    );

    intersection #(.MIN_T(32'sh0002_0000)) dut_mt (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (in_valid),
        .i_triangle (tri_v),
        .i_ray      (ray_v),
        .o_valid    (m_valid),
        .o_result   (m_result),
        .o_invalid  (m_invalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input int id);
        tri_v = '0;
        ray_v = '0;
        tri_v[1][0] = ONE;
        tri_v[2][1] = ONE;
        ray_v[1][0] = QTR;
        ray_v[1][1] = QTR;
        ray_v[1][2] = ONE;
        ray_v[0][2] = NEG1;
        case (id)
            1: ray_v[0][2] = ONE;
            2: begin ray_v[1][0] = ONE;  ray_v[1][1] = ONE;  end
            3: begin ray_v[1][0] = HALF; ray_v[1][1] = HALF; end
            4: begin ray_v[0][0] = ONE;  ray_v[0][2] = '0;   end
            5: begin tri_v[0][0] = 32'h7FFF_0000; tri_v[1][0] = 32'h8000_0000; end
            6: begin
                tri_v[1][0] = '0;  tri_v[1][1] = ONE;
                tri_v[2][0] = ONE; tri_v[2][1] = '0;
            end
            7: ray_v[1][2] = THR;
            8: ray_v[1][2] = TWO;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset o_valid: got %b want 0", o_valid); end
        n_checks++;
        if (o_result !== 1'b0) begin n_fail++; $display("FAIL reset o_result: got %b want 0", o_result); end
        n_checks++;
        if (o_invalid !== 1'b0) begin n_fail++; $display("FAIL reset o_invalid: got %b want 0", o_invalid); end
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset mt o_valid: got %b want 0", m_valid); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_cases();
        for (int id = 0; id < 9; id++) begin
            set_pair(id);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            tick();
            n_checks++;
            if (o_valid !== 1'b0) begin
                n_fail++; $display("FAIL %s early o_valid: got %b want 0", names[id], o_valid);
            end
            tick();
            n_checks++;
            if (o_valid !== 1'b1) begin
                n_fail++; $display("FAIL %s o_valid: got %b want 1", names[id], o_valid);
            end
            n_checks++;
            if (o_result !== exp_res[id]) begin
                n_fail++; $display("FAIL %s o_result: got %b want %b", names[id], o_result, exp_res[id]);
            end
            n_checks++;
            if (o_invalid !== exp_inv[id]) begin
                n_fail++; $display("FAIL %s o_invalid: got %b want %b", names[id], o_invalid, exp_inv[id]);
            end
            n_checks++;
            if (m_result !== exp_mres[id] || m_valid !== 1'b1 || m_invalid !== exp_inv[id]) begin
                n_fail++;
                $display("FAIL %s min_t=2 v/r/i: got %b%b%b want 1%b%b", names[id],
                         m_valid, m_result, m_invalid, exp_mres[id], exp_inv[id]);
            end
            tick();
            n_checks++;
            if (o_valid !== 1'b0 || o_result !== 1'b0 || o_invalid !== 1'b0) begin
                n_fail++; $display("FAIL %s idle after: got v/r/i %b%b%b want 000", names[id],
                                   o_valid, o_result, o_invalid);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int id = 0; id < 5; id++) begin
            set_pair(id);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_result !== exp_res[j] || o_invalid !== exp_inv[j]) begin
                n_fail++; $display("FAIL b2b %s v/r/i: got %b%b%b want 1%b%b", names[j],
                                   o_valid, o_result, o_invalid, exp_res[j], exp_inv[j]);
            end
            tick();
        end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b tail o_valid: got %b want 0", o_valid); end
    endtask

    task automatic test_bubble();
        set_pair(0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        set_pair(2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== 1'b1) begin
            n_fail++; $display("FAIL bubble first v/r: got %b%b want 11", o_valid, o_result);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_result !== 1'b0 || o_invalid !== 1'b0) begin
            n_fail++; $display("FAIL bubble gap v/r/i: got %b%b%b want 000", o_valid, o_result, o_invalid);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== 1'b0) begin
            n_fail++; $display("FAIL bubble second v/r: got %b%b want 10", o_valid, o_result);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        for (int id = 0; id < 5; id++) begin
            set_pair(id);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== 1'b1) begin
            n_fail++; $display("FAIL midrst pre v/r: got %b%b want 11", o_valid, o_result);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_result !== 1'b0 || o_invalid !== 1'b0) begin
            n_fail++; $display("FAIL midrst async v/r/i: got %b%b%b want 000", o_valid, o_result, o_invalid);
        end
        tick();
        tick();
        #2;
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            n_checks++;
            if (o_valid !== 1'b0 || m_valid !== 1'b0) begin
                n_fail++; $display("FAIL midrst stale cycle %0d: got %b/%b want 0/0", j, o_valid, m_valid);
            end
        end
        set_pair(0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== 1'b1 || o_invalid !== 1'b0) begin
            n_fail++; $display("FAIL midrst recovery v/r/i: got %b%b%b want 110", o_valid, o_result, o_invalid);
        end
    endtask

    initial begin
        test_reset();
        test_single_cases();
        test_back_to_back();
        test_bubble();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
